mdu_iterative: RTL and testbench
================================

# mdu_iterative

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core, sitting beside the combinational ALU. It executes signed and unsigned multiply and divide over a programmable number of cycles and owns the architectural HI/LO registers. It raises `busy` so hazard logic can stall any MDU-dependent instruction.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_CYCLES`, 5: multiply latency in cycles, must be ≥1.
- `DIV_CYCLES`, 10: divide latency in cycles, must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mdu_op`  in  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11–15 NONE.
- `start`  in  1  qualifies `mdu_op` for this cycle.
- `srcA`  in  WIDTH  rs operand.
- `srcB`  in  WIDTH  rt operand.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  HI register (feeds MFHI).
- `lo`  out  WIDTH  LO register (feeds MFLO).

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, cycle counter=0, latched op=NONE.
- Idle (`busy`=0) state:
  - `start`=1 with MULT/MULTU/DIV/DIVU/MADD*/MSUB* latches `srcA`, `srcB` and the op.
  - It loads the counter with `MULT_CYCLES` (multiply class) or `DIV_CYCLES` (divide class).
  - The state moves to Busy.
- MTHI/MTLO in Idle:
  - They write `srcA` into `hi`/`lo` at that edge.
  - They do not assert `busy` and take no latency.
- Busy state:
  - The counter decrements each edge.
  - On the edge where the counter reaches 0, the result commits to `hi`/`lo` and the state returns to Idle.
  - Any `start` (including MTHI/MTLO) during Busy is ignored. Upstream stall logic guarantees none occurs.
- Arithmetic, on a 2·WIDTH product:
  - MULT: signed×signed.
  - MULTU: unsigned×unsigned.
  - `{hi,lo}` = product.
- Divide:
  - DIV: signed; quotient truncates toward zero and the remainder takes the sign of the dividend. `lo`=quotient, `hi`=remainder.
  - DIVU: unsigned.
  - Divisor 0: the op still occupies `DIV_CYCLES` and `hi`/`lo` are left unchanged.
  - DIV of most-negative by −1: `lo`=most-negative, `hi`=0, with no exception.
- Operands are captured at start; later changes to `srcA`/`srcB` have no effect.
- NONE, or `start`=0: no state change.

## Timing
- `start` is sampled at rising edge T0 in Idle.
  - `busy`=1 from after T0 until after edge T0+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy` is high for exactly N cycles.
- `hi`/`lo` update at edge T0+N, the same edge `busy` falls. The new values are visible in the following cycle.
- A back-to-back `start` is accepted in the first cycle `busy`=0.
- MTHI/MTLO: the value is visible the cycle after the start edge.
- `reset_n` low mid-operation:
  - It immediately clears `busy`, the counter, `hi` and `lo`.
  - The pending result is discarded.
- `busy` is a register output with no combinational path from `start`. Hazard logic ORs `start` with `busy` itself.

## Configuration
- `MDU_MADD_EN` defined:
  - MADD/MADDU/MSUB/MSUBU are supported. Each computes `{hi,lo}` ± product (signed or unsigned per op, wrap modulo 2^(2·WIDTH)).
  - The HI/LO value used is the one present at the start edge.
  - Latency is `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: op codes 7–10 decode as NONE, with no `busy` and no state change.

## Test plan
- MULT `srcA`=0xFFFFFFFF, `srcB`=2 → `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV `srcA`=0xFFFFFFF9 (−7), `srcB`=2 → `busy` 10 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1.
- Preload `hi`=0x11, `lo`=0x22 via MTHI/MTLO (no `busy`, visible the next cycle). DIV by 0 → `busy` 10 cycles, `hi`/`lo` still 0x11/0x22.
- MULT start, then `start` with MTLO 0xDEAD during cycle 2 of busy → ignored. The final `lo` equals the product, and the next op is accepted the first cycle after `busy` falls.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Assert `reset_n`=0 in cycle 4 of a later DIV → `busy`=0, `hi`=`lo`=0 immediately, and no late commit.
- With `MDU_MADD_EN`: `hi`=0, `lo`=0xFFFFFFFF, then MADDU 1×1 → `hi`=1, `lo`=0. Without the macro, the same op leaves `hi`/`lo` unchanged and `busy`=0.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers; results commit after a fixed cycle count.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mdu_iterative #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       mdu_op,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned MAX_CY = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_CY + 1);

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state;
    op_e              op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             is_mul_c;
    logic             is_div_c;
    logic [PW-1:0]    prod_s_c;
    logic [PW-1:0]    prod_u_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH-1:0] qmag_c;
    logic [WIDTH-1:0] rmag_c;
    logic [WIDTH-1:0] quo_s_c;
    logic [WIDTH-1:0] rem_s_c;
    logic [PW-1:0]    res_c;
    logic             wr_c;

    // Start decode: multiply-accumulate ops only count when the feature is built in
    always_comb begin
        is_mul_c = 1'b0;
        is_div_c = 1'b0;
        case (mdu_op)
            OP_MULT, OP_MULTU:                     is_mul_c = 1'b1;
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:  is_mul_c = MADD_EN;
            OP_DIV, OP_DIVU:                       is_div_c = 1'b1;
            default: ;
        endcase
    end

    // Result datapath on the captured operands; signed divide works on magnitudes
    always_comb begin
        prod_s_c = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u_c = {WIDTH'(0), a_q} * {WIDTH'(0), b_q};
        mag_a_c  = a_q[WIDTH-1] ? (WIDTH'(0) - a_q) : a_q;
        mag_b_c  = b_q[WIDTH-1] ? (WIDTH'(0) - b_q) : b_q;
        qmag_c   = mag_a_c / mag_b_c;
        rmag_c   = mag_a_c % mag_b_c;
        quo_s_c  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (WIDTH'(0) - qmag_c) : qmag_c;
        rem_s_c  = a_q[WIDTH-1] ? (WIDTH'(0) - rmag_c) : rmag_c;

        res_c = {hi, lo};
        wr_c  = 1'b0;
        case (op_q)
            OP_MULT:  begin res_c = prod_s_c;              wr_c = 1'b1; end
            OP_MULTU: begin res_c = prod_u_c;              wr_c = 1'b1; end
            OP_MADD:  begin res_c = {hi, lo} + prod_s_c;   wr_c = 1'b1; end
            OP_MADDU: begin res_c = {hi, lo} + prod_u_c;   wr_c = 1'b1; end
            OP_MSUB:  begin res_c = {hi, lo} - prod_s_c;   wr_c = 1'b1; end
            OP_MSUBU: begin res_c = {hi, lo} - prod_u_c;   wr_c = 1'b1; end
            OP_DIV:   begin res_c = {rem_s_c, quo_s_c};    wr_c = (b_q != WIDTH'(0)); end
            OP_DIVU:  begin res_c = {a_q % b_q, a_q / b_q}; wr_c = (b_q != WIDTH'(0)); end
            default: ;
        endcase
    end

    // Control FSM, counter and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul_c || is_div_c) begin
                            op_q  <= op_e'(mdu_op);
                            a_q   <= srcA;
                            b_q   <= srcB;
                            cnt   <= is_div_c ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state <= BUSY;
                            busy  <= 1'b1;
                        end else if (mdu_op == OP_MTHI) begin
                            hi <= srcA;
                        end else if (mdu_op == OP_MTLO) begin
                            lo <= srcA;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        op_q  <= OP_NONE;
                        if (wr_c) begin
                            hi <= res_c[PW-1:WIDTH];
                            lo <= res_c[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed, table-driven bench for mdu_iterative with hand-written multi-cycle corner sequences.
module tb_mdu_iterative;

    logic        clk;
    logic        reset_n;
    logic [3:0]  mdu_op;
    logic        start;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    mdu_iterative #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu_op  (mdu_op),
        .start   (start),
        .srcA    (srcA),
        .srcB    (srcB),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one op from idle and count busy cycles; returns at the first negedge with busy low
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        mdu_op = op; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0; srcA = $urandom; srcB = $urandom;
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    int cyc;

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b0; start = 1'b0; mdu_op = 4'd0; srcA = '0; srcB = '0;

        vecs.push_back('{"mult_neg1x2",   4'd1,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{"multu_big_x2",  4'd2,  32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE});
        vecs.push_back('{"div_m7_2",      4'd3,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"divu_7_2",      4'd4,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003});
        vecs.push_back('{"div_min_m1",    4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000});
        vecs.push_back('{"mult_m3_m5",    4'd1,  32'hFFFFFFFD, 32'hFFFFFFFB, 5,  32'h00000000, 32'h0000000F});
        vecs.push_back('{"multu_2p16sq",  4'd2,  32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000});
        vecs.push_back('{"div_7_m2",      4'd3,  32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{"divu_max_10",   4'd4,  32'hFFFFFFFF, 32'd10,       10, 32'h00000005, 32'h19999999});
        vecs.push_back('{"mthi_11",       4'd5,  32'h00000011, 32'd0,        0,  32'h00000011, 32'h19999999});
        vecs.push_back('{"mtlo_22",       4'd6,  32'h00000022, 32'd0,        0,  32'h00000011, 32'h00000022});
        vecs.push_back('{"div_by_zero",   4'd3,  32'd5,        32'd0,        10, 32'h00000011, 32'h00000022});
        vecs.push_back('{"op11_none",     4'd11, 32'h12345678, 32'd3,        0,  32'h00000011, 32'h00000022});
        vecs.push_back('{"mthi_0",        4'd5,  32'h00000000, 32'd0,        0,  32'h00000000, 32'h00000022});
        vecs.push_back('{"mtlo_ones",     4'd6,  32'hFFFFFFFF, 32'd0,        0,  32'h00000000, 32'hFFFFFFFF});
`ifdef MDU_MADD_EN
        vecs.push_back('{"maddu_1x1",     4'd8,  32'd1,        32'd1,        5,  32'h00000001, 32'h00000000});
        vecs.push_back('{"msub_1x1",      4'd9,  32'd1,        32'd1,        5,  32'h00000000, 32'hFFFFFFFF});
`else
        vecs.push_back('{"maddu_1x1",     4'd8,  32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF});
        vecs.push_back('{"msub_1x1",      4'd9,  32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF});
`endif

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        // MTLO arriving mid-multiply is ignored; next op accepted right as busy falls
        @(negedge clk);
        mdu_op = 4'd1; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            if (cyc == 2) begin
                mdu_op = 4'd6; srcA = 32'h0000DEAD; start = 1'b1;
            end else begin
                start = 1'b0; mdu_op = 4'd0;
            end
            @(negedge clk);
        end
        check("ignore_mtlo_cycles", 32'(cyc), 32'd5);
        check("ignore_mtlo_hi", hi, 32'd0);
        check("ignore_mtlo_lo", lo, 32'd12);
        mdu_op = 4'd2; srcA = 32'd2; srcB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        check("b2b_busy", 32'(busy), 32'd1);
        cyc = 1;
        @(negedge clk);
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_cycles", 32'(cyc), 32'd5);
        check("b2b_lo", lo, 32'd6);

        // Reset in the middle of a divide discards the pending result
        @(negedge clk);
        mdu_op = 4'd4; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_late_busy", 32'(busy), 32'd0);
        check("rst_late_hi", hi, 32'd0);
        check("rst_late_lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
